regfile_wb_arbiter: RTL and testbench

//   Shares the single write port (We/addr3/din) of the 32x32 RegisterFile among

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/regfile_wb_arbiter.sv | 84 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: register file geometry and writeback requester indices.
package cpu_pkg;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned REG_DW  = 32;
    localparam int unsigned WB_NREQ = 3;
    localparam int unsigned GID_W   = 3;

    localparam int unsigned WB_ALU = 0;
    localparam int unsigned WB_LD  = 1;
    localparam int unsigned WB_MUL = 2;

    // Increment a requester index, wrapping to 0 at n.
    function automatic logic [GID_W-1:0] wrap_inc(input logic [GID_W-1:0] idx,
                                                  input int unsigned n);
        if (32'(idx) + 32'd1 >= n) begin
            return '0;
        end
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr (wrapping) wins.
module rr_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned N = WB_NREQ
) (
    input  logic [N-1:0]       req,
    input  logic [GID_W-1:0]   ptr,
    input  logic               en,
    output logic [N-1:0]       gnt,
    output logic [GID_W-1:0]   gnt_idx
);

    localparam int unsigned CW = GID_W + 1;

    logic [CW-1:0] cand;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                cand = {1'b0, ptr} + CW'(k);
                if (cand >= CW'(N)) begin
                    cand = cand - CW'(N);
                end
                for (int j = 0; j < N; j++) begin
                    if (!found && cand == CW'(j) && req[j]) begin
                        found   = 1'b1;
                        gnt[j]  = 1'b1;
                        gnt_idx = GID_W'(j);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among writeback units (round-robin, registered)
// and forwards the in-flight write onto both read ports.
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned NREQ = WB_NREQ,
    parameter int unsigned DW   = REG_DW,
    parameter int unsigned AW   = REG_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                rf_we,
    output logic [AW-1:0]       rf_waddr,
    output logic [DW-1:0]       rf_wdata,
    output logic [GID_W-1:0]    grant_id,
    input  logic [AW-1:0]       rd_addr1,
    input  logic [AW-1:0]       rd_addr2,
    input  logic [DW-1:0]       rf_dout1,
    input  logic [DW-1:0]       rf_dout2,
    output logic [DW-1:0]       rd_data1,
    output logic [DW-1:0]       rd_data2
);

    logic [GID_W-1:0] ptr;
    logic [GID_W-1:0] gnt_idx;
    logic [NREQ-1:0]  gnt;
    logic             arb_en;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;

    // Gating with rst_n keeps req_ready low for the whole reset assertion.
    assign arb_en = rst_n & ~stall;

    rr_arbiter #(
        .N(NREQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            grant_id <= '0;
        end else if (|gnt) begin
            ptr      <= wrap_inc(gnt_idx, NREQ);
            rf_we    <= 1'b1;
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
            grant_id <= gnt_idx;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Register 0 is deliberately not special-cased here.
    assign rd_data1 = (rf_we && rf_waddr == rd_addr1) ? rf_wdata : rf_dout1;
    assign rd_data2 = (rf_we && rf_waddr == rd_addr2) ? rf_wdata : rf_dout2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter against a behavioural writeback model.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               stall;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rf_we;
    logic [AW-1:0]      rf_waddr;
    logic [DW-1:0]      rf_wdata;
    logic [2:0]         grant_id;
    logic [AW-1:0]      rd_addr1, rd_addr2;
    logic [DW-1:0]      rf_dout1, rf_dout2;
    logic [DW-1:0]      rd_data1, rd_data2;

    // Behavioural register file feeding the read ports.
    logic [DW-1:0] regs [32];
    assign rf_dout1 = regs[rd_addr1];
    assign rf_dout2 = regs[rd_addr2];

    int pass_cnt = 0;
    int total_cnt = 0;

    // Model state: rotation pointer and the write currently presented to the RF.
    int            m_ptr;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_gid;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .grant_id  (grant_id),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rf_dout1  (rf_dout1),
        .rf_dout2  (rf_dout2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2)
    );

    function automatic int model_winner(logic [NREQ-1:0] v, logic st, logic rn, int p);
        if (!rn || st) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(int w);
        logic [NREQ-1:0] r;
        r = '0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_gid = 0;
    endtask

    // Advance one clock, updating model and RF, then settle 1ns after the edge.
    task automatic tick();
        int w;
        w = model_winner(req_valid, stall, rst_n, m_ptr);
        @(posedge clk);
        if (m_we) regs[m_addr] = m_data;
        if (!rst_n) begin
            model_reset();
        end else if (w >= 0) begin
            m_we = 1'b1; m_addr = req_addr[w*AW +: AW]; m_data = req_data[w*DW +: DW];
            m_gid = w; m_ptr = (w + 1) % NREQ;
        end else begin
            m_we = 1'b0;
        end
        #1;
    endtask

    task automatic set_req(int i, logic [AW-1:0] a, logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; req_valid = '1;
        req_addr = {$urandom, $urandom}; req_data = {$urandom, $urandom, $urandom};
        model_reset();
        #2;
        total_cnt++; if (req_ready !== 3'b000) $display("FAIL reset_ready: got %b exp 000", req_ready); else pass_cnt++;
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL reset_we: got %b exp 0", rf_we); else pass_cnt++;
        total_cnt++; if (rf_waddr !== '0) $display("FAIL reset_waddr: got %h exp 0", rf_waddr); else pass_cnt++;
        total_cnt++; if (rf_wdata !== '0) $display("FAIL reset_wdata: got %h exp 0", rf_wdata); else pass_cnt++;
        total_cnt++; if (grant_id !== 3'd0) $display("FAIL reset_gid: got %0d exp 0", grant_id); else pass_cnt++;
        tick();
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL reset_we_edge: got %b exp 0", rf_we); else pass_cnt++;
        req_valid = '0;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single_write();
        req_valid = 3'b010;
        set_req(1, 5'd3, 32'hAA55FFF0);
        #1;
        total_cnt++; if (req_ready !== 3'b010) $display("FAIL single_ready: got %b exp 010", req_ready); else pass_cnt++;
        tick();
        req_valid = '0; rd_addr1 = 5'd3; rd_addr2 = 5'd4;
        #1;
        total_cnt++; if (rf_we !== 1'b1) $display("FAIL single_we: got %b exp 1", rf_we); else pass_cnt++;
        total_cnt++; if (rf_waddr !== 5'd3) $display("FAIL single_waddr: got %0d exp 3", rf_waddr); else pass_cnt++;
        total_cnt++; if (rf_wdata !== 32'hAA55FFF0) $display("FAIL single_wdata: got %h exp aa55fff0", rf_wdata); else pass_cnt++;
        total_cnt++; if (grant_id !== 3'd1) $display("FAIL single_gid: got %0d exp 1", grant_id); else pass_cnt++;
        total_cnt++; if (rd_data1 !== 32'hAA55FFF0) $display("FAIL single_fwd: got %h exp aa55fff0", rd_data1); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL single_pulse: got %b exp 0", rf_we); else pass_cnt++;
        total_cnt++; if (rd_data1 !== 32'hAA55FFF0) $display("FAIL single_readback: got %h exp aa55fff0", rd_data1); else pass_cnt++;
    endtask

    task automatic test_rotation();
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), $urandom);
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            #1;
            total_cnt++; if (req_ready !== onehot(k % NREQ)) $display("FAIL rot_ready[%0d]: got %b exp %b", k, req_ready, onehot(k % NREQ)); else pass_cnt++;
            tick();
            total_cnt++; if (grant_id !== 3'(k % NREQ)) $display("FAIL rot_gid[%0d]: got %0d exp %0d", k, grant_id, k % NREQ); else pass_cnt++;
            total_cnt++; if (rf_waddr !== AW'(k % NREQ + 1)) $display("FAIL rot_waddr[%0d]: got %0d exp %0d", k, rf_waddr, k % NREQ + 1); else pass_cnt++;
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_forwarding();
        req_valid = 3'b001;
        set_req(0, 5'd5, 32'h12345678);
        tick();
        req_valid = '0; rd_addr1 = 5'd5; rd_addr2 = 5'd6;
        #1;
        total_cnt++; if (rd_data1 !== 32'h12345678) $display("FAIL fwd_port1: got %h exp 12345678", rd_data1); else pass_cnt++;
        total_cnt++; if (rd_data2 !== regs[6]) $display("FAIL fwd_port2: got %h exp %h", rd_data2, regs[6]); else pass_cnt++;
        rd_addr1 = 5'd6; rd_addr2 = 5'd5;
        #1;
        total_cnt++; if (rd_data2 !== 32'h12345678) $display("FAIL fwd_port2_hit: got %h exp 12345678", rd_data2); else pass_cnt++;
        tick();
    endtask

    task automatic test_stall();
        int exp_w;
        req_valid = 3'b001;
        set_req(0, 5'd7, $urandom); set_req(2, 5'd8, $urandom);
        tick();
        stall = 1'b1; req_valid = 3'b101;
        #1;
        total_cnt++; if (req_ready !== 3'b000) $display("FAIL stall_ready0: got %b exp 000", req_ready); else pass_cnt++;
        total_cnt++; if (rf_we !== 1'b1) $display("FAIL stall_inflight: got %b exp 1", rf_we); else pass_cnt++;
        for (int c = 0; c < 2; c++) begin
            tick();
            total_cnt++; if (rf_we !== 1'b0) $display("FAIL stall_we[%0d]: got %b exp 0", c, rf_we); else pass_cnt++;
            total_cnt++; if (req_ready !== 3'b000) $display("FAIL stall_ready[%0d]: got %b exp 000", c, req_ready); else pass_cnt++;
        end
        stall = 1'b0;
        #1;
        exp_w = model_winner(req_valid, stall, rst_n, m_ptr);
        total_cnt++; if (req_ready !== onehot(exp_w) || req_ready !== 3'b100) $display("FAIL stall_release: got %b exp 100", req_ready); else pass_cnt++;
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_async_reset();
        req_valid = 3'b010;
        set_req(1, 5'd9, $urandom);
        tick();
        req_valid = 3'b111;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL areset_we: got %b exp 0", rf_we); else pass_cnt++;
        total_cnt++; if (req_ready !== 3'b000) $display("FAIL areset_ready: got %b exp 000", req_ready); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        #1;
        total_cnt++; if (req_ready !== 3'b001) $display("FAIL areset_first: got %b exp 001", req_ready); else pass_cnt++;
        tick();
        total_cnt++; if (grant_id !== 3'd0) $display("FAIL areset_gid: got %0d exp 0", grant_id); else pass_cnt++;
        req_valid = '0;
        tick();
    endtask

    task automatic test_back_to_back_random();
        logic [DW-1:0] e1, e2;
        for (int c = 0; c < 300; c++) begin
            req_valid = NREQ'($urandom);
            stall = ($urandom_range(0, 5) == 0);
            req_addr = {$urandom, $urandom};
            req_data = {$urandom, $urandom, $urandom};
            rd_addr1 = ($urandom_range(0, 1) == 0) ? m_addr : AW'($urandom);
            rd_addr2 = ($urandom_range(0, 1) == 0) ? m_addr : AW'($urandom);
            #1;
            e1 = (m_we && m_addr == rd_addr1) ? m_data : regs[rd_addr1];
            e2 = (m_we && m_addr == rd_addr2) ? m_data : regs[rd_addr2];
            total_cnt++; if (req_ready !== onehot(model_winner(req_valid, stall, rst_n, m_ptr))) $display("FAIL rnd_ready[%0d]: got %b exp %b", c, req_ready, onehot(model_winner(req_valid, stall, rst_n, m_ptr))); else pass_cnt++;
            total_cnt++; if (rf_we !== m_we) $display("FAIL rnd_we[%0d]: got %b exp %b", c, rf_we, m_we); else pass_cnt++;
            total_cnt++; if (rf_waddr !== m_addr || rf_wdata !== m_data) $display("FAIL rnd_wr[%0d]: got %h/%h exp %h/%h", c, rf_waddr, rf_wdata, m_addr, m_data); else pass_cnt++;
            total_cnt++; if (grant_id !== 3'(m_gid)) $display("FAIL rnd_gid[%0d]: got %0d exp %0d", c, grant_id, m_gid); else pass_cnt++;
            total_cnt++; if (rd_data1 !== e1 || rd_data2 !== e2) $display("FAIL rnd_rd[%0d]: got %h/%h exp %h/%h", c, rd_data1, rd_data2, e1, e2); else pass_cnt++;
            tick();
        end
        req_valid = '0; stall = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        rd_addr1 = '0; rd_addr2 = '0;
        test_reset();
        test_single_write();
        test_rotation();
        test_forwarding();
        test_stall();
        test_async_reset();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
